// File: rtl/bus_master_arb.sv
// Round-robin arbiter sharing one az_bus master port among NM requesters.
// Optional BUSY watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_master_arb #(
    parameter int unsigned NM             = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NM-1:0]      req_valid,
    input  logic [NM-1:0]      req_wr,
    input  logic [NM*32-1:0]   req_addr,
    input  logic [NM*32-1:0]   req_wdata,
    output logic [NM-1:0]      req_ack,
    output logic               req_err,
    output logic [31:0]        req_rdata,
    output logic               bus_req,
    output logic               bus_wr,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wdata,
    input  logic [31:0]        bus_rdata,
    input  logic               bus_rdy
);

    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]    state_q;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] rr_ptr_next;
    logic [IW-1:0] win;
    logic          found;
    logic          timeout;
    logic          complete;

    // First requester at or above rr_ptr, wrapping past NM-1 to 0.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] idx_w;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NM; k++) begin
            idx   = (32'(rr_ptr_q) + k) % NM;
            idx_w = IW'(idx);
            if (!found && req_valid[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    assign timeout = (state_q == StBusy) && !bus_rdy &&
                     (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == StIdle) begin
            to_cnt_q <= '0;
        end else if (!bus_rdy) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign complete    = (state_q == StBusy) && (bus_rdy || timeout);
    assign rr_ptr_next = (gnt_q == IW'(NM - 1)) ? '0 : gnt_q + 1'b1;
    assign bus_req     = (state_q == StBusy);

    always_comb begin
        req_ack   = '0;
        req_rdata = '0;
        req_err   = 1'b0;
        if (complete) begin
            req_ack[gnt_q] = 1'b1;
            // A ready in the timeout cycle wins over the forced termination.
            if (bus_rdy) begin
                req_rdata = bus_rdata;
            end else begin
                req_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q   <= StBusy;
                        gnt_q     <= win;
                        bus_wr    <= req_wr[win];
                        bus_addr  <= req_addr[32*win +: 32];
                        bus_wdata <= req_wdata[32*win +: 32];
                    end
                end
                StBusy: begin
                    if (complete) begin
                        state_q  <= StIdle;
                        rr_ptr_q <= rr_ptr_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_arb.sv
// Self-checking bench for bus_master_arb against a transaction-level round-robin model.
// Timeout scenario runs only when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_master_arb;

    localparam int NM = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     req_valid;
    logic [NM-1:0]     req_wr;
    logic [NM*32-1:0]  req_addr;
    logic [NM*32-1:0]  req_wdata;
    logic [NM-1:0]     req_ack;
    logic              req_err;
    logic [31:0]       req_rdata;
    logic              bus_req;
    logic              bus_wr;
    logic [31:0]       bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_rdy;

    int total    = 0;
    int pass_cnt = 0;
    int ref_ptr  = 0;

    always #5 clk = ~clk;

    bus_master_arb #(
        .NM             (NM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .bus_req   (bus_req),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rdy   (bus_rdy)
    );

    // Rotate the request vector so the pointer sits at bit 0, take the lowest set bit.
    function automatic int rr_pick(input logic [NM-1:0] v, input int ptr);
        logic [2*NM-1:0] dbl;
        dbl = {v, v} >> ptr;
        for (int j = 0; j < NM; j++) begin
            if (dbl[j]) return (ptr + j) % NM;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] w);
        req_valid[i]          = 1'b1;
        req_wr[i]             = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = w;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        bus_rdy   = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        ref_ptr = 0;
    endtask

    // Called just after a negedge of an IDLE cycle with at least one request raised.
    task automatic run_xfer(input int waits, input logic [31:0] rd, input bit rereq);
        int            win;
        logic [31:0]   ea, ew;
        logic          ewr;
        logic [NM-1:0] eack;
        logic [31:0]   erd;
        win = rr_pick(req_valid, ref_ptr);
        ea  = req_addr[32*win +: 32];
        ew  = req_wdata[32*win +: 32];
        ewr = req_wr[win];
        bus_rdy   = 1'($urandom);
        bus_rdata = $urandom;
        #1;
        total++;
        if (bus_req !== 1'b0 || req_ack !== '0 || req_rdata !== '0)
            $display("FAIL idle_outputs: bus_req=%b ack=%b rdata=%h, required 0/0/0",
                     bus_req, req_ack, req_rdata);
        else pass_cnt++;
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            bus_rdy   = (k == waits);
            bus_rdata = (k == waits) ? rd : $urandom;
            #1;
            eack = '0;
            erd  = '0;
            if (k == waits) begin
                eack[win] = 1'b1;
                erd       = rd;
            end
            total++;
            if (bus_req !== 1'b1 || bus_addr !== ea || bus_wdata !== ew || bus_wr !== ewr)
                $display("FAIL bus_hold: req=%b addr=%h wdata=%h wr=%b, required 1 %h %h %b",
                         bus_req, bus_addr, bus_wdata, bus_wr, ea, ew, ewr);
            else pass_cnt++;
            total++;
            if (req_ack !== eack || req_rdata !== erd || req_err !== 1'b0)
                $display("FAIL ack: ack=%b rdata=%h err=%b, required %b %h 0",
                         req_ack, req_rdata, req_err, eack, erd);
            else pass_cnt++;
        end
        ref_ptr = (win + 1) % NM;
        @(negedge clk);
        bus_rdy = 1'b0;
        if (rereq) set_req(win, 1'($urandom), $urandom, $urandom);
        else req_valid[win] = 1'b0;
        #1;
        total++;
        if (bus_req !== 1'b0 || req_ack !== '0)
            $display("FAIL idle_gap: bus_req=%b ack=%b, required 0 0", bus_req, req_ack);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus_rdy   = 1'b1;
        bus_rdata = 32'hA5A5_5A5A;
        req_valid = '1;
        req_wr    = '1;
        req_addr  = {NM{32'hFFFF_0000}};
        req_wdata = {NM{32'h0000_FFFF}};
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (bus_req !== 1'b0 || bus_wr !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0)
            $display("FAIL reset_bus: req=%b wr=%b addr=%h wdata=%h, required all 0",
                     bus_req, bus_wr, bus_addr, bus_wdata);
        else pass_cnt++;
        total++;
        if (req_ack !== '0 || req_err !== 1'b0 || req_rdata !== '0)
            $display("FAIL reset_resp: ack=%b err=%b rdata=%h, required all 0",
                     req_ack, req_err, req_rdata);
        else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_single_read();
        set_req(2, 1'b0, 32'h0000_1000, $urandom);
        run_xfer(0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_wait_states();
        set_req(0, 1'b1, 32'h2000_0040, 32'h1234_5678);
        run_xfer(3, $urandom, 1'b0);
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < NM; i++) set_req(i, 1'($urandom), $urandom, $urandom);
        repeat (6) run_xfer(int'($urandom_range(0, 2)), $urandom, 1'b1);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        set_req(2, 1'b0, 32'h0000_3000, $urandom);
        run_xfer(0, $urandom, 1'b0);
        set_req(0, 1'b0, 32'h0000_4000, $urandom);
        set_req(1, 1'b1, 32'h0000_5000, $urandom);
        run_xfer(1, $urandom, 1'b0);
        run_xfer(0, $urandom, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_req(3, 1'b1, 32'h0000_6000, 32'h6666_6666);
        bus_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (bus_req !== 1'b1)
            $display("FAIL mid_busy: bus_req=%b, required 1", bus_req);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_req !== 1'b0 || req_ack !== '0)
            $display("FAIL mid_async: bus_req=%b ack=%b, required 0 0", bus_req, req_ack);
        else pass_cnt++;
        req_valid = '0;
        bus_rdy   = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (req_ack !== '0 || bus_req !== 1'b0)
            $display("FAIL mid_noack: ack=%b bus_req=%b, required 0 0", req_ack, bus_req);
        else pass_cnt++;
        rst_n   = 1'b1;
        bus_rdy = 1'b0;
        ref_ptr = 0;
        // Pointer is 0 only if reset cleared it, so requester 1 must beat requester 3.
        set_req(1, 1'b0, 32'h0000_7000, $urandom);
        set_req(3, 1'b0, 32'h0000_8000, $urandom);
        run_xfer(0, $urandom, 1'b0);
        run_xfer(1, $urandom, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NM; i++) begin
                if (!req_valid[i] && ($urandom % 2 == 0))
                    set_req(i, 1'($urandom), $urandom, $urandom);
            end
            if (req_valid == '0) set_req(int'($urandom_range(0, NM - 1)), 1'b0, $urandom, $urandom);
            run_xfer(int'($urandom_range(0, 3)), $urandom, 1'($urandom));
        end
        req_valid = '0;
        @(negedge clk);
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int            win;
        logic [NM-1:0] eack;
        set_req(1, 1'b0, 32'h0000_9000, $urandom);
        win     = rr_pick(req_valid, ref_ptr);
        bus_rdy = 1'b0;
        #1;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            bus_rdata = $urandom | 32'h1;
            #1;
            eack = '0;
            if (k == TO - 1) eack[win] = 1'b1;
            total++;
            if (bus_req !== 1'b1 || req_ack !== eack || req_err !== (k == TO - 1) ||
                req_rdata !== '0)
                $display("FAIL timeout_c%0d: req=%b ack=%b err=%b rdata=%h, required 1 %b %b 0",
                         k, bus_req, req_ack, req_err, req_rdata, eack, (k == TO - 1));
            else pass_cnt++;
        end
        ref_ptr = (win + 1) % NM;
        @(negedge clk);
        req_valid[win] = 1'b0;
        #1;
        total++;
        if (bus_req !== 1'b0)
            $display("FAIL timeout_idle: bus_req=%b, required 0", bus_req);
        else pass_cnt++;
        set_req(2, 1'b1, 32'h0000_A000, $urandom);
        run_xfer(2, $urandom, 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_wait_states();
        test_fairness();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
